// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, LSB-first shift-out with frame strobe and done pulse.
// Optional even-parity bit after the data word, enabled by defining PISO_TX_PARITY_EN.
//
// state | meaning
// IDLE  | ready for a word; sout/sframe low
// SHIFT | frame bits on sout, each held CLKS_PER_BIT clocks
module piso_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  // bit 0 of the frame goes straight to sout at accept; shreg holds the rest
  logic [NBITS-2:0] shreg, shreg_nx;
  logic [BW-1:0]    bit_idx, bit_idx_nx;
  logic [TW-1:0]    tick, tick_nx;
  logic             sout_nx, sframe_nx, done_nx;
  logic [NBITS-1:0] word;

`ifdef PISO_TX_PARITY_EN
  assign word = {^data, data};
`else
  assign word = data;
`endif

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tick    <= '0;
      sout    <= 1'b0;
      sframe  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_idx <= bit_idx_nx;
      tick    <= tick_nx;
      sout    <= sout_nx;
      sframe  <= sframe_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    tick_nx    = tick;
    sout_nx    = sout;
    sframe_nx  = sframe;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        sout_nx   = 1'b0;
        sframe_nx = 1'b0;
        if (load_valid) begin
          shreg_nx   = word[NBITS-1:1];
          sout_nx    = word[0];
          sframe_nx  = 1'b1;
          bit_idx_nx = '0;
          tick_nx    = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick == TICK_LAST) begin
          tick_nx = '0;
          if (bit_idx == BIT_LAST) begin
            state_nx  = IDLE;
            done_nx   = 1'b1;
            sframe_nx = 1'b0;
            sout_nx   = 1'b0;
          end else begin
            sout_nx    = shreg[0];
            shreg_nx   = shreg >> 1;
            bit_idx_nx = bit_idx + BW'(1);
          end
        end else begin
          tick_nx = tick + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one instance with CLKS_PER_BIT=1, one with CLKS_PER_BIT=3.
// Expected streams are hand-written LSB first, parity bit in position 4 (used only with PISO_TX_PARITY_EN).
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d1, d3;
  logic       lv1, lv3;
  logic       rdy1, sout1, sfr1, done1;
  logic       rdy3, sout3, sfr3, done3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .data(d1), .load_valid(lv1),
    .load_ready(rdy1), .sout(sout1), .sframe(sfr1), .done(done1)
  );

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(3)) u_dut_c3 (
    .clk(clk), .rst_n(rst_n), .data(d3), .load_valid(lv3),
    .load_ready(rdy3), .sout(sout3), .sframe(sfr3), .done(done3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input bit sel, input string tag, input logic e_sout,
                            input logic e_sfr, input logic e_done, input logic e_rdy);
    check_val({tag, " sout"},   sel ? sout3 : sout1, e_sout);
    check_val({tag, " sframe"}, sel ? sfr3  : sfr1,  e_sfr);
    check_val({tag, " done"},   sel ? done3 : done1, e_done);
    check_val({tag, " ready"},  sel ? rdy3  : rdy1,  e_rdy);
  endtask

  // Presents word before the next edge (accept edge), then checks every cycle of the
  // frame and the done cycle. Returns #1 after the edge that opens the done cycle.
  task automatic send_frame(input bit sel, input logic [3:0] word, input logic [4:0] exp_bits,
                            input int c, input bit poke);
    if (sel) begin d3 = word; lv3 = 1'b1; end
    else     begin d1 = word; lv1 = 1'b1; end
    @(posedge clk); #1;
    lv1 = 1'b0; lv3 = 1'b0;
    d1 = ~word; d3 = ~word;
    for (int i = 0; i < NB; i++) begin
      for (int t = 0; t < c; t++) begin
        if (poke && i == 1 && t == 0) begin
          if (sel) begin d3 = 4'hF; lv3 = 1'b1; end
          else     begin d1 = 4'hF; lv1 = 1'b1; end
        end
        check_outs(sel, $sformatf("w%0h b%0d t%0d", word, i, t), exp_bits[i], 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        lv1 = 1'b0; lv3 = 1'b0;
      end
    end
    check_outs(sel, $sformatf("w%0h donecyc", word), 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle_check(input bit sel, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check_outs(sel, $sformatf("idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    lv1 = 1'b0; lv3 = 1'b0;
    d1 = 4'h0;  d3 = 4'h0;
    #1;
    check_outs(1'b0, "rst c1", 1'b0, 1'b0, 1'b0, 1'b1);
    check_outs(1'b1, "rst c3", 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_outs(1'b0, "post rst", 1'b0, 1'b0, 1'b0, 1'b1);

    // 4'hA, C=1: 0,1,0,1 ; parity 0
    send_frame(1'b0, 4'hA, 5'b0_1010, 1, 1'b0);
    idle_check(1'b0, 2);

    // 4'h5, C=3: 111 000 111 000 ; parity 0
    send_frame(1'b1, 4'h5, 5'b0_0101, 3, 1'b0);
    idle_check(1'b1, 2);

    // back-to-back: 4'h3 then 4'hC loaded in the done cycle
    send_frame(1'b0, 4'h3, 5'b0_0011, 1, 1'b0);
    send_frame(1'b0, 4'hC, 5'b0_1100, 1, 1'b0);
    idle_check(1'b0, 1);

    // busy load of 4'hF during 4'h6 is ignored
    send_frame(1'b0, 4'h6, 5'b0_0110, 1, 1'b1);
    idle_check(1'b0, 3);

    // parity cases: 4'h7 -> parity 1, 4'h3 -> parity 0
    send_frame(1'b0, 4'h7, 5'b1_0111, 1, 1'b0);
    idle_check(1'b0, 1);
    send_frame(1'b0, 4'h3, 5'b0_0011, 1, 1'b0);
    idle_check(1'b0, 1);
    send_frame(1'b1, 4'hB, 5'b1_1011, 3, 1'b0);
    idle_check(1'b1, 1);

    // reset in the middle of 4'h9
    d1 = 4'h9; lv1 = 1'b1;
    @(posedge clk); #1;
    lv1 = 1'b0; d1 = 4'h0;
    check_outs(1'b0, "mid b0", 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outs(1'b0, "mid b1", 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outs(1'b0, "mid b2", 1'b0, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_outs(1'b0, "mid rst async", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_outs(1'b0, $sformatf("mid rst hold%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk) rst_n = 1'b1;
    send_frame(1'b0, 4'h9, 5'b0_1001, 1, 1'b0);
    idle_check(1'b0, 1);

    // reset and load together: nothing captured
    rst_n = 1'b0; d1 = 4'hF; lv1 = 1'b1;
    @(posedge clk); #1;
    check_outs(1'b0, "rst+load", 1'b0, 1'b0, 1'b0, 1'b1);
    lv1 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle_check(1'b0, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter. The partner end of the team's parallel-capture registers.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on a single line, LSB first.
- Each bit is held for CLKS_PER_BIT clocks. A frame strobe and a completion pulse let the downstream serial-in receiver align its capture.

Parameters:
- WIDTH, 4, data word width in bits; legal values >= 2.
- CLKS_PER_BIT, 1, clock cycles each serial bit is held; legal values >= 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- data  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  upstream asserts when data is valid.
- load_ready  output  1  high when the block can accept a word.
- sout  output  1  serial data, registered.
- sframe  output  1  high while a frame's bits are on sout, registered.
- done  output  1  one-cycle pulse after the last bit of a frame, registered.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE.
  - Outputs: load_ready=1, sout=0, sframe=0, done=0.
  - Internal: shift register=0, bit counter=0, tick counter=0.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, sframe=0, sout=0.
  - Accept occurs on a posedge with load_valid=1 and load_ready=1. On accept: shreg<=data, bit_idx<=0, tick<=0, state<=SHIFT.
  - data need not be held after the accept edge.
- SHIFT:
  - load_ready=0, sframe=1, sout=current LSB of shreg.
  - tick counts 0..CLKS_PER_BIT-1. When tick wraps, shreg shifts right by one and bit_idx increments.
  - Leave SHIFT when the last bit's last tick completes (bit_idx=NBITS-1 and tick=CLKS_PER_BIT-1). On that edge: state<=IDLE, done<=1, sframe<=0, sout<=0.
  - NBITS = WIDTH, or WIDTH+1 when parity is enabled.
- Timing, for a word accepted at edge k with C=CLKS_PER_BIT:
  - data[i] is on sout for the cycles after edges k+i*C through k+(i+1)*C-1.
  - done=1 and load_ready=1 in the single cycle after edge k+NBITS*C.
  - done is high for exactly one cycle per completed frame.
- Back-to-back frames:
  - A load presented in the done cycle is accepted.
  - The next frame's first bit appears the following cycle.
  - Minimum frame period is NBITS*C+1 cycles. There is always one idle cycle, with sframe=0 and sout=0, between frames.
- load_valid while busy (load_ready=0) is ignored. No buffering and no error flag.
- Counters:
  - tick is clog2(CLKS_PER_BIT) bits wide, minimum 1 bit.
  - bit_idx is clog2(NBITS+1) bits wide.
  - With CLKS_PER_BIT=1, tick is constant 0 and each bit lasts one cycle.
- Reset mid-frame:
  - Outputs return to reset values asynchronously.
  - No done pulse is generated and the partial frame is discarded.
  - After rst_n rises, the first accept is possible on the first posedge.
- Simultaneous reset and load: reset wins and no word is captured.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of all WIDTH data bits, captured at accept) is transmitted after data[WIDTH-1] for C cycles, with sframe still high.
  - NBITS=WIDTH+1. done follows the parity bit.
- When undefined: no parity bit, NBITS=WIDTH, and no parity logic is synthesized.

Test Plan:
- WIDTH=4, C=1, load data=4'hA at edge 0 -> sout=0,1,0,1 in cycles 1-4 with sframe=1. Cycle 5: done=1, load_ready=1, sframe=0.
- C=3, data=4'h5 -> sout=1,1,1,0,0,0,1,1,1,0,0,0 over cycles 1-12. done in cycle 13 only.
- Back-to-back: 4'h3, then 4'hC presented in the done cycle -> bit streams 1,1,0,0 | gap cycle (sframe=0) | 0,0,1,1. Two done pulses, 5 cycles apart.
- Busy load: during frame 4'h6, pulse load_valid with 4'hF -> ignored; stream stays 0,1,1,0 and no second frame starts.
- Reset mid-frame: assert rst_n=0 after bit 1 of 4'h9 -> sout=0, sframe=0, load_ready=1 immediately. No done. A new load after release transmits correctly.
- PISO_TX_PARITY_EN, C=1, data=4'h7 -> sout=1,1,1,0,1 (parity=1). done in cycle 6. data=4'h3 -> parity bit 0.
